ovengame: RTL and testbench
===========================

Name: ovengame

Overview:
- Minigame slot responder: "oven timing" reaction game.
- Plugs into the top-level game slots behind the output mux, alongside the memory, cake and clothes games, and uses the same slot interface.
- Top pulses jogar. The block runs ROUNDS rounds: after a fixed wait it lights a pseudo-random target button, and the player must press exactly that button before timeout.
- Ends by holding pronto with a 3-bit score.

Parameters:
- ROUNDS, 7: rounds per game (1..7).
- T_ESPERA, 500: cycles in ESPERA before the target is shown.
- T_RESP_FACIL, 1500: response window in cycles when dificuldade=0.
- T_RESP_DIFICIL, 700: response window in cycles when dificuldade=1.
- T_FEEDBACK, 500: cycles ACERTO/ERRO feedback is held.

Ports:
- clock  in  1  system (divided) clock.
- reset  in  1  asynchronous, active-high; clock clock.
- jogar  in  1  start pulse, one cycle, from top start_game state.
- dificuldade  in  1  sampled in PREPARA only.
- botoes  in  7  buttons, active-high (already inverted by top), not debounced.
- estado  out  4  current state code (hex display).
- jogadas  out  7  LED pattern.
- pontuacao  out  3  score.
- pronto  out  1  game finished, level.

Behaviour:
- Reset (async, any state): state INICIAL; jogadas=0, pontuacao=0, pronto=0, round=0, LFSR=3'b001, botoes_prev=0.
- State codes on estado: INICIAL 0, PREPARA 1, ESPERA 2, MOSTRA 3, ACERTO 4, ERRO 5, SOLTA 6, PROXIMA 7, FIM 4'hF.
- INICIAL: on jogar=1, go to PREPARA next cycle. Otherwise stay.
- PREPARA (1 cycle):
  - pontuacao=0, round=0, LFSR=001.
  - Latch dificuldade into resp_limit (T_RESP_DIFICIL if 1, else T_RESP_FACIL).
  - Clear timer. Go to ESPERA.
- ESPERA: count T_ESPERA cycles, then MOSTRA. Button activity is ignored.
- MOSTRA:
  - On entry, target = one-hot bit (LFSR-1). jogadas = target for the whole state. Timer restarts at 0.
  - Press = rising edge: botoes!=0 this cycle and botoes_prev==0 (botoes_prev is registered each cycle).
  - Press with botoes==target: ACERTO, and pontuacao increments (saturates at 7).
  - Press with any other pattern (including target plus extra bits): ERRO.
  - Timer reaching resp_limit with no press: ERRO.
  - Press and timeout in the same cycle: the press wins.
  - A button already held on entering MOSTRA does not count until it is released and pressed again.
- ACERTO: jogadas=7'h7F, hold T_FEEDBACK cycles, then SOLTA.
- ERRO: jogadas=0, hold T_FEEDBACK cycles, then SOLTA.
- SOLTA: jogadas=0. Wait until botoes==0, then PROXIMA.
- PROXIMA (1 cycle):
  - round += 1. LFSR advances: q <= {q[1:0], q[2]^q[1]}.
  - If round+1==ROUNDS, go to FIM; else go to ESPERA.
- LFSR sequence from 001: 001, 010, 101, 011, 111, 110, 100, then repeats. Targets by round: bit0, bit1, bit4, bit2, bit6, bit5, bit3.
- FIM:
  - pronto=1 (registered, asserted on the first cycle in FIM). jogadas=0. pontuacao held.
  - On jogar, go to PREPARA; pronto=0 from that cycle on.
- jogar is ignored in all states except INICIAL and FIM.
- Timer: one counter, cleared on every state entry, width ≥ clog2 of the largest parameter.
- Outputs:
  - pontuacao and pronto are registered.
  - jogadas is registered or a decode of state and target, with no glitch requirement.
  - estado is a direct decode of the state register.

Decomposition:
- Shared include (ovengame_defs): state encodings and the LFSR seed. The top's estado display decode reuses these.
- Timer: reuse the existing contador_m, with zera_s on state change.
- One natural sub-module: lfsr3 (clock, reset, load, advance, q[2:0]).

Test Plan:
Use ROUNDS=3, T_ESPERA=4, T_RESP_FACIL=8, T_RESP_DIFICIL=4, T_FEEDBACK=2.
1. Reset then jogar pulse -> estado 0, then 1, then 2 for 4 cycles, then 3 with jogadas=7'b0000001; pontuacao=0, pronto=0.
2. Correct presses every round (botoes=0000001, then 0000010, then 0010000, each released in SOLTA) -> pontuacao=3, estado=F, pronto=1 held.
3. dificuldade=1 with no presses -> each MOSTRA lasts exactly 4 cycles then ERRO. End state: pontuacao=0, pronto=1. With dificuldade=0, MOSTRA lasts 8 cycles.
4. Wrong or extra button: round 1 botoes=0000011 -> ERRO, pontuacao stays 0. Button held through SOLTA -> no PROXIMA until release.
5. Button held from ESPERA into MOSTRA -> no press detected. Release then press target -> ACERTO.
6. Boundaries:
   - Async reset mid-MOSTRA -> immediately estado=0, jogadas=0, pontuacao=0.
   - jogar during ESPERA -> ignored.
   - jogar in FIM -> pronto drops, new game begins at target bit0.

Source files
------------

// File: rtl/ovengame_pkg.sv
// Shared definitions for the oven timing minigame: state codes, LFSR seed
// and the target decode used by the top.
package ovengame_pkg;

  typedef enum logic [3:0] {
    ST_INICIAL = 4'h0,
    ST_PREPARA = 4'h1,
    ST_ESPERA  = 4'h2,
    ST_MOSTRA  = 4'h3,
    ST_ACERTO  = 4'h4,
    ST_ERRO    = 4'h5,
    ST_SOLTA   = 4'h6,
    ST_PROXIMA = 4'h7,
    ST_FIM     = 4'hF
  } estado_t;

  localparam logic [2:0] LFSR_SEED = 3'b001;
  localparam logic [6:0] JOG_TODAS = 7'h7F;
  localparam logic [6:0] JOG_NADA  = 7'h00;

  // LFSR value q (never zero) lights button q-1
  function automatic logic [6:0] alvo_onehot(input logic [2:0] q);
    logic [6:0] r;
    r = 7'b0;
    for (int i = 0; i < 7; i++) begin
      r[i] = (q == 3'(i + 1));
    end
    return r;
  endfunction

endpackage

// File: rtl/ovengame_lfsr3.sv
// 3-bit maximal-length LFSR that picks the target button for each round.
module lfsr3
  import ovengame_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       advance,
  output logic [2:0] q
);

  logic [2:0] q_r;

  // seed reload has priority over advancing
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_r <= LFSR_SEED;
    end else if (load) begin
      q_r <= LFSR_SEED;
    end else if (advance) begin
      q_r <= {q_r[1:0], q_r[2] ^ q_r[1]};
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/ovengame.sv
// Oven timing reaction minigame: lights a target button each round and
// scores presses of exactly that button inside the response window.
module ovengame
  import ovengame_pkg::*;
#(
  parameter int ROUNDS         = 7,
  parameter int T_ESPERA       = 500,
  parameter int T_RESP_FACIL   = 1500,
  parameter int T_RESP_DIFICIL = 700,
  parameter int T_FEEDBACK     = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       dificuldade,
  input  logic [6:0] botoes,
  output logic [3:0] estado,
  output logic [6:0] jogadas,
  output logic [2:0] pontuacao,
  output logic       pronto
);

  localparam int T_MAX_A = (T_ESPERA > T_FEEDBACK) ? T_ESPERA : T_FEEDBACK;
  localparam int T_MAX_B = (T_RESP_FACIL > T_RESP_DIFICIL) ? T_RESP_FACIL : T_RESP_DIFICIL;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int TW      = $clog2(T_MAX + 1);

  // comparisons are against the last cycle of each interval
  localparam logic [TW-1:0] LIM_ESPERA   = TW'(T_ESPERA - 1);
  localparam logic [TW-1:0] LIM_FEEDBACK = TW'(T_FEEDBACK - 1);
  localparam logic [TW-1:0] LIM_FACIL    = TW'(T_RESP_FACIL - 1);
  localparam logic [TW-1:0] LIM_DIFICIL  = TW'(T_RESP_DIFICIL - 1);

  estado_t       state_r, state_s;
  logic [TW-1:0] tmr_r;
  logic [TW-1:0] resp_limit_r;
  logic [2:0]    round_r;
  logic [6:0]    botoes_prev_r;
  logic [2:0]    pontuacao_r;
  logic          pronto_r;
  logic [6:0]    jogadas_r;
  logic [2:0]    lfsr_q_s;
  logic [6:0]    alvo_s;
  logic          press_s;

  lfsr3 u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .load    (state_r == ST_PREPARA),
    .advance (state_r == ST_PROXIMA),
    .q       (lfsr_q_s)
  );

  assign alvo_s  = alvo_onehot(lfsr_q_s);
  assign press_s = (botoes != 7'b0) && (botoes_prev_r == 7'b0);

  // next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_INICIAL: if (jogar) state_s = ST_PREPARA; else state_s = ST_INICIAL;
      ST_PREPARA: state_s = ST_ESPERA;
      ST_ESPERA:  if (tmr_r == LIM_ESPERA) state_s = ST_MOSTRA; else state_s = ST_ESPERA;
      ST_MOSTRA: begin
        // a press in the final window cycle beats the timeout
        if (press_s) begin
          if (botoes == alvo_s) state_s = ST_ACERTO; else state_s = ST_ERRO;
        end else if (tmr_r == resp_limit_r) begin
          state_s = ST_ERRO;
        end else begin
          state_s = ST_MOSTRA;
        end
      end
      ST_ACERTO:  if (tmr_r == LIM_FEEDBACK) state_s = ST_SOLTA; else state_s = ST_ACERTO;
      ST_ERRO:    if (tmr_r == LIM_FEEDBACK) state_s = ST_SOLTA; else state_s = ST_ERRO;
      ST_SOLTA:   if (botoes == 7'b0) state_s = ST_PROXIMA; else state_s = ST_SOLTA;
      ST_PROXIMA: begin
        if (({1'b0, round_r} + 4'd1) == 4'(ROUNDS)) state_s = ST_FIM; else state_s = ST_ESPERA;
      end
      ST_FIM:     if (jogar) state_s = ST_PREPARA; else state_s = ST_FIM;
      default:    state_s = ST_INICIAL;
    endcase
  end

  // state register and the shared interval timer, cleared on every state change
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_INICIAL;
      tmr_r   <= {TW{1'b0}};
    end else begin
      state_r <= state_s;
      if (state_s != state_r) tmr_r <= {TW{1'b0}};
      else                    tmr_r <= tmr_r + TW'(1);
    end
  end

  // round bookkeeping, score, edge detector and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      botoes_prev_r <= 7'b0;
      round_r       <= 3'd0;
      resp_limit_r  <= LIM_FACIL;
      pontuacao_r   <= 3'd0;
      pronto_r      <= 1'b0;
      jogadas_r     <= JOG_NADA;
    end else begin
      botoes_prev_r <= botoes;
      if (state_r == ST_PREPARA) begin
        round_r      <= 3'd0;
        resp_limit_r <= dificuldade ? LIM_DIFICIL : LIM_FACIL;
      end else if (state_r == ST_PROXIMA) begin
        round_r <= round_r + 3'd1;
      end else begin
        round_r <= round_r;
      end
      if (state_s == ST_PREPARA) begin
        pontuacao_r <= 3'd0;
      end else if ((state_r == ST_MOSTRA) && (state_s == ST_ACERTO) && (pontuacao_r != 3'd7)) begin
        pontuacao_r <= pontuacao_r + 3'd1;
      end else begin
        pontuacao_r <= pontuacao_r;
      end
      pronto_r <= (state_s == ST_FIM);
      case (state_s)
        ST_MOSTRA: jogadas_r <= alvo_s;
        ST_ACERTO: jogadas_r <= JOG_TODAS;
        default:   jogadas_r <= JOG_NADA;
      endcase
    end
  end

  assign estado    = state_r;
  assign jogadas   = jogadas_r;
  assign pontuacao = pontuacao_r;
  assign pronto    = pronto_r;

endmodule

// File: tb/tb_ovengame.sv
// Randomized scoreboard bench for ovengame: stimulus queues per-round and
// per-game expectations, a monitor checks them as the game progresses.
module tb_ovengame;

  localparam int ROUNDS     = 3;
  localparam int T_ESPERA   = 4;
  localparam int T_FACIL    = 8;
  localparam int T_DIFICIL  = 4;
  localparam int T_FEEDBACK = 2;

  localparam int M_OK      = 0;
  localparam int M_WRONG   = 1;
  localparam int M_TIMEOUT = 2;
  localparam int M_HOLD    = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       jogar;
  logic       dificuldade;
  logic [6:0] botoes;
  logic [3:0] estado;
  logic [6:0] jogadas;
  logic [2:0] pontuacao;
  logic       pronto;

  always #5 clock = ~clock;

  ovengame #(
    .ROUNDS(ROUNDS), .T_ESPERA(T_ESPERA), .T_RESP_FACIL(T_FACIL),
    .T_RESP_DIFICIL(T_DIFICIL), .T_FEEDBACK(T_FEEDBACK)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .dificuldade(dificuldade),
    .botoes(botoes), .estado(estado), .jogadas(jogadas),
    .pontuacao(pontuacao), .pronto(pronto)
  );

  typedef struct {
    int st;
    int len;
    int tgt;
    int score;
  } exp_t;

  exp_t exp_q[$];
  int   fin_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tgt_bit [7] = '{0, 1, 4, 2, 6, 5, 3};

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int   prev_est = 0;
  int   dur = 1;
  int   rounds_done = 0;
  logic prev_pronto = 1'b0;
  int   jog_entry = 0;
  int   cur;
  exp_t e_mon;

  always begin
    @(posedge clock or posedge reset);
    if (reset) begin
      prev_est = 0; dur = 1; rounds_done = 0; prev_pronto = 1'b0;
    end else begin
      #1;
      cur = int'(estado);
      chk("pronto_level", int'(pronto), (cur == 15) ? 1 : 0);
      if (cur != 3) chk("jogadas", int'(jogadas), (cur == 4) ? 127 : 0);
      if (pronto && !prev_pronto) begin
        checks++;
        if (fin_q.size() == 0) begin
          errors++;
          $display("FAIL final_score: pronto rose with no game expected");
        end else begin
          checks--;
          chk("final_score", int'(pontuacao), fin_q.pop_front());
        end
      end
      case (prev_est)
        0: chk("inicial_next", cur, jogar ? 1 : 0);
        1: begin
          chk("prepara_next", cur, 2);
          chk("score_cleared", int'(pontuacao), 0);
          rounds_done = 0;
        end
        2: if (cur != 2) begin
          chk("espera_len", dur, T_ESPERA);
          chk("espera_next", cur, 3);
        end
        3: if (cur != 3) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL round_queue: MOSTRA ended with no round expected");
          end else begin
            checks--;
            e_mon = exp_q.pop_front();
            chk("round_result", cur, e_mon.st);
            chk("mostra_len", dur, e_mon.len);
            chk("target", jog_entry, e_mon.tgt);
            chk("round_score", int'(pontuacao), e_mon.score);
          end
        end
        4, 5: if (cur != prev_est) begin
          chk("feedback_len", dur, T_FEEDBACK);
          chk("feedback_next", cur, 6);
        end
        6: chk("solta_next", cur, (botoes == 7'b0) ? 7 : 6);
        7: begin
          rounds_done++;
          chk("proxima_next", cur, (rounds_done == ROUNDS) ? 15 : 2);
        end
        15: chk("fim_next", cur, jogar ? 1 : 15);
        default: chk("state_code_valid", prev_est, 0);
      endcase
      if (cur == 3 && prev_est != 3) jog_entry = int'(jogadas);
      if (cur == prev_est) dur++; else dur = 1;
      prev_est    = cur;
      prev_pronto = pronto;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_estado(input int s, input int budget);
    int n = 0;
    while (int'(estado) != s && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("wait_estado", int'(estado), s);
  endtask

  task automatic play_game(input int dif_sel, input int fmode, input int abort_round);
    int         dif, limit, mode, d, h, score;
    logic [6:0] tgt, pat;
    exp_t       e;
    dif   = (dif_sel < 0) ? int'($urandom_range(0, 1)) : dif_sel;
    limit = (dif != 0) ? T_DIFICIL : T_FACIL;
    dificuldade = (dif != 0);
    repeat ($urandom_range(1, 3)) @(negedge clock);
    jogar = 1'b1;
    @(negedge clock);
    jogar = 1'b0;
    score = 0;
    for (int r = 0; r < ROUNDS; r++) begin
      mode = (fmode < 0) ? int'($urandom_range(0, 3)) : fmode;
      tgt  = 7'b1 << tgt_bit[r];
      d    = $urandom_range(0, limit - 1);
      do pat = 7'($urandom_range(1, 127)); while (pat == tgt);
      wait_estado(2, 64);
      if ($urandom_range(0, 2) == 0) begin
        jogar = 1'b1;
        @(negedge clock);
        jogar = 1'b0;
      end
      if (mode == M_HOLD) botoes = tgt;
      wait_estado(3, 64);
      if (abort_round == r) begin
        #2 reset = 1'b1;
        #1;
        chk("async_estado", int'(estado), 0);
        chk("async_jogadas", int'(jogadas), 0);
        chk("async_score", int'(pontuacao), 0);
        exp_q.delete();
        fin_q.delete();
        botoes = 7'b0;
        @(negedge clock);
        reset = 1'b0;
        return;
      end
      e.tgt = int'(tgt);
      case (mode)
        M_OK:      begin e.st = 4; e.len = d + 1; end
        M_WRONG:   begin e.st = 5; e.len = d + 1; end
        M_TIMEOUT: begin e.st = 5; e.len = limit; end
        default:   begin e.st = 4; e.len = 3; end
      endcase
      if (e.st == 4 && score < 7) score++;
      e.score = score;
      exp_q.push_back(e);
      dificuldade = 1'($urandom_range(0, 1));
      if (mode != M_TIMEOUT) begin
        if (mode == M_HOLD) begin
          @(negedge clock) botoes = 7'b0;
          @(negedge clock) botoes = tgt;
        end else begin
          repeat (d) @(negedge clock);
          botoes = (mode == M_OK) ? tgt : pat;
        end
        h = $urandom_range(1, 6);
        repeat (h) @(negedge clock);
        botoes = 7'b0;
      end
    end
    fin_q.push_back(score);
    wait_estado(15, 64);
    repeat ($urandom_range(1, 4)) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; jogar = 1'b0; dificuldade = 1'b0; botoes = 7'b0;
    repeat (3) @(negedge clock);
    chk("reset_estado", int'(estado), 0);
    chk("reset_jogadas", int'(jogadas), 0);
    chk("reset_score", int'(pontuacao), 0);
    chk("reset_pronto", int'(pronto), 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    play_game(0, M_OK, -1);
    play_game(1, M_TIMEOUT, -1);
    play_game(0, M_TIMEOUT, -1);
    play_game(0, M_WRONG, -1);
    play_game(-1, M_HOLD, -1);
    repeat (20) play_game(-1, -1, -1);
    play_game(-1, M_OK, 1);
    play_game(-1, -1, -1);
    repeat (5) @(negedge clock);
    chk("rounds_drained", exp_q.size(), 0);
    chk("games_drained", fin_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
